// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer beside EXE: owns HI/LO and runs fixed-latency multiplies
// and a 32-step radix-2 restoring divide, stalling EXE while a result is pending.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [5:0]  op,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic        op_ready,
  input  logic        cancel,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int unsigned W        = 32;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned DIV_LAST = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic [W-1:0]   src_a;
  logic [W-1:0]   src_b;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;
  logic           mul_signed;
  logic           neg_q;
  logic           neg_r;
  logic           div_zero;

  logic           op_legal;
  logic           accept;
  logic           is_mul;
  logic           is_div;
  logic           div_signed;
  logic           mul_last;
  logic           div_take;
  logic [W-1:0]   in0_mag;
  logic [W-1:0]   in1_mag;
  logic [W-1:0]   rem_nxt;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;
  logic [W:0]     div_shift;
  logic [2*W-1:0] ext_a;
  logic [2*W-1:0] ext_b;
  logic [2*W-1:0] product;

  // Acceptance, datapath helpers and EXE-facing status
  always_comb begin
    op_legal   = (|op) & ~(|(op & (op - OP_W'(1))));
    op_ready   = (state == ST_IDLE) & ~cancel;
    accept     = op_valid & op_ready & op_legal;
    is_mul     = op[0] | op[1];
    is_div     = op[2] | op[3];
    div_signed = op[2];

    in0_mag = (div_signed & in0[W-1]) ? W'(-in0) : in0;
    in1_mag = (div_signed & in1[W-1]) ? W'(-in1) : in1;

    // Sign-extending for MULT keeps the low 64 bits of an unsigned multiply exact
    ext_a   = {{W{mul_signed & src_a[W-1]}}, src_a};
    ext_b   = {{W{mul_signed & src_b[W-1]}}, src_b};
    product = ext_a * ext_b;

    div_shift = {rem, quot[W-1]};
    div_take  = div_shift >= {1'b0, src_b};
    rem_nxt   = div_take ? (div_shift[W-1:0] - src_b) : div_shift[W-1:0];
    q_fix     = neg_q ? W'(-quot) : quot;
    r_fix     = neg_r ? W'(-rem) : rem;

    mul_last = (state == ST_MUL) && (cnt == CNT_W'(MUL_LAT - 1));
    busy     = (state != ST_IDLE);
    done     = ~cancel & (mul_last | (state == ST_FIX));
    stall    = busy & (rd_req | op_valid);
    rd_data  = rd_sel ? hi : lo;
    hi_out   = hi;
    lo_out   = lo;
  end

  // Sequencer state, operand latches and architectural HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      src_a      <= '0;
      src_b      <= '0;
      quot       <= '0;
      rem        <= '0;
      mul_signed <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op[4]) hi <= in0;
            if (op[5]) lo <= in0;
            if (is_mul) begin
              state      <= ST_MUL;
              cnt        <= '0;
              src_a      <= in0;
              src_b      <= in1;
              mul_signed <= op[0];
            end
            if (is_div) begin
              state    <= ST_DIV;
              cnt      <= '0;
              src_a    <= in0;
              src_b    <= in1_mag;
              quot     <= in0_mag;
              rem      <= '0;
              neg_q    <= div_signed & (in0[W-1] ^ in1[W-1]);
              neg_r    <= div_signed & in0[W-1];
              div_zero <= (in1 == '0);
            end
          end
        end
        ST_MUL: begin
          if (cancel) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (mul_last) begin
            hi    <= product[2*W-1:W];
            lo    <= product[W-1:0];
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DIV: begin
          if (cancel) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            rem  <= rem_nxt;
            quot <= {quot[W-2:0], div_take};
            if (cnt == CNT_W'(DIV_LAST)) begin
              state <= ST_FIX;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_FIX: begin
          // Divide-by-zero reports all-ones quotient and the raw dividend
          if (!cancel) begin
            lo <= div_zero ? '1 : q_fix;
            hi <= div_zero ? src_a : r_fix;
          end
          state <= ST_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboarded bench for mdu_ctrl: directed corner cases plus random ops against an
// arithmetic reference model; a monitor checks HI/LO whenever done pulses.
module tb_mdu_ctrl;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_LAT = 33;
  localparam logic [5:0] OP_MULT  = 6'b000001;
  localparam logic [5:0] OP_MULTU = 6'b000010;
  localparam logic [5:0] OP_DIV   = 6'b000100;
  localparam logic [5:0] OP_DIVU  = 6'b001000;
  localparam logic [5:0] OP_MTHI  = 6'b010000;
  localparam logic [5:0] OP_MTLO  = 6'b100000;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [5:0]  op;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        op_ready;
  logic        cancel;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] sb_q[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op       (op),
    .in0      (in0),
    .in1      (in1),
    .op_ready (op_ready),
    .cancel   (cancel),
    .rd_req   (rd_req),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {HI,LO} from plain integer arithmetic
  function automatic logic [63:0] ref_model(input logic [5:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sp;
    int          sa;
    int          sb;
    logic [63:0] r;
    r = {hi_m, lo_m};
    case (o)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        r  = 64'(sp);
      end
      OP_MULTU: r = 64'(a) * 64'(b);
      OP_DIV: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          sa = a;
          sb = b;
          r  = {32'(sa % sb), 32'(sa / sb)};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = {hi_m, lo_m};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: on every done pulse, pop the oldest expected result and check HI/LO after the edge
  always begin : monitor
    logic [63:0] e;
    @(negedge clk);
    #1;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: done=1 while no result pending at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        @(posedge clk);
        #1;
        check("hi_result", hi_out, e[63:32]);
        check("lo_result", lo_out, e[31:0]);
      end
    end
  end

  // Issue one op; rd_at > 0 raises an HI read from that busy cycle on
  task automatic run_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int rd_at);
    logic [63:0] e;
    int          n;
    int          lat;
    logic        got;
    logic        exp_stall;
    @(negedge clk);
    op_valid = 1'b1;
    op = o;
    in0 = a;
    in1 = b;
    #1 check("op_ready_idle", 32'(op_ready), 32'd1);
    e = ref_model(o, a, b);
    @(negedge clk);
    op_valid = 1'b0;
    if (o == OP_MTHI || o == OP_MTLO) begin
      if (o == OP_MTHI) hi_m = a;
      else lo_m = a;
      #1;
      check("mt_hi", hi_out, hi_m);
      check("mt_lo", lo_out, lo_m);
      check("mt_busy", 32'(busy), 32'd0);
      rd_req = 1'b1;
      rd_sel = o[4];
      #1;
      check("mt_rd_data", rd_data, a);
      check("mt_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1 rd_req = 1'b0;
    end else begin
      sb_q.push_back(e);
      hi_m = e[63:32];
      lo_m = e[31:0];
      lat = (o == OP_MULT || o == OP_MULTU) ? MUL_LAT : DIV_LAT;
      n = 0;
      got = 1'b0;
      while (!got && n < 80) begin
        n++;
        rd_req = (rd_at != 0 && n >= rd_at);
        rd_sel = 1'b1;
        op_valid = (rd_at == 0 && n == 1);
        exp_stall = rd_req | op_valid;
        #1;
        check("busy", 32'(busy), 32'd1);
        check("stall", 32'(stall), 32'(exp_stall));
        if (op_valid) check("op_ready_busy", 32'(op_ready), 32'd0);
        got = done;
        if (!got) @(negedge clk);
      end
      check("latency", 32'(n), 32'(lat));
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      check("busy_after", 32'(busy), 32'd0);
      if (rd_at != 0) begin
        check("stall_after", 32'(stall), 32'd0);
        check("rd_after_done", rd_data, hi_m);
      end
      rd_req = 1'b0;
    end
  endtask

  task automatic read_check(input logic s);
    @(negedge clk);
    rd_req = 1'b1;
    rd_sel = s;
    #1;
    check("rd_data", rd_data, s ? hi_m : lo_m);
    check("rd_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1 rd_req = 1'b0;
  endtask

  // Start an op and flush it in busy cycle cancel_at (cycle 1 = first busy cycle)
  task automatic run_cancel(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                            input int cancel_at);
    @(negedge clk);
    op_valid = 1'b1;
    op = o;
    in0 = a;
    in1 = b;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (cancel_at - 1) @(negedge clk);
    cancel = 1'b1;
    #1;
    check("cancel_done", 32'(done), 32'd0);
    check("cancel_op_ready", 32'(op_ready), 32'd0);
    @(negedge clk);
    cancel = 1'b0;
    #1;
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_idle_ready", 32'(op_ready), 32'd1);
    check("cancel_hi", hi_out, hi_m);
    check("cancel_lo", lo_out, lo_m);
  endtask

  // Present an op that must not be accepted (cancelled or malformed)
  task automatic run_reject(input logic [5:0] o, input logic [31:0] a, input logic c);
    @(negedge clk);
    op_valid = 1'b1;
    op = o;
    in0 = a;
    cancel = c;
    #1 if (c) check("cancel_same_cycle_ready", 32'(op_ready), 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    cancel = 1'b0;
    #1;
    check("reject_busy", 32'(busy), 32'd0);
    check("reject_hi", hi_out, hi_m);
    check("reject_lo", lo_out, lo_m);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [5:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    rst_n = 1'b0;
    op_valid = 1'b0;
    op = '0;
    in0 = '0;
    in1 = '0;
    cancel = 1'b0;
    rd_req = 1'b0;
    rd_sel = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, 0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(OP_DIVU,  32'd100, 32'd0, 0);
    run_op(OP_DIV,   32'hFFFF_FF9C, 32'd0, 0);
    run_op(OP_MTLO,  32'h0000_1234, 32'd0, 0);
    run_op(OP_DIVU,  32'd10, 32'd3, 5);
    run_cancel(OP_DIVU, 32'd1000, 32'd7, 11);
    run_cancel(OP_MULT, 32'd5, 32'd6, 1);
    run_reject(OP_MTHI, 32'hDEAD_BEEF, 1'b1);
    run_reject(6'b000011, 32'hDEAD_BEEF, 1'b0);
    run_reject(6'b000000, 32'hDEAD_BEEF, 1'b0);
    read_check(1'b0);
    read_check(1'b1);

    // Reset in the middle of a divide discards it
    @(negedge clk);
    op_valid = 1'b1;
    op = OP_DIV;
    in0 = 32'd77;
    in1 = 32'd5;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hi_m = '0;
    lo_m = '0;
    #1;
    check("midrst_hi", hi_out, 32'd0);
    check("midrst_lo", lo_out, 32'd0);
    check("midrst_op_ready", 32'(op_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      o = 6'b000001 << $urandom_range(0, 5);
      a = rand_operand();
      b = rand_operand();
      run_op(o, a, b, 0);
      if ($urandom_range(0, 2) == 0) read_check(1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    #1 check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
